// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and defaults for the countdown timer and its prescaler.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DIV_DEFAULT = 1000;

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler: counts DIV-1 down to 0 while enabled and emits a one-cycle tick at 0.
module tick_divider #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Disabled cycles hold the phase, so a pause resumes mid-period.
  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= TOP;
    else if (clr || tick)  cnt <= TOP;
    else if (en)           cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter with run/pause control; stops at zero and flags completion.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start_stop,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             done_pulse
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             pulse_n;
  logic             tick, presc_en, presc_clr;

  // A start_stop or load in RUN steals the cycle from the prescaler.
  assign presc_en  = (state == ST_RUN) && !start_stop && !load;
  assign presc_clr = load || (state == ST_IDLE) || (state == ST_DONE);

  tick_divider #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      done_pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    pulse_n = 1'b0;
    if (load) begin
      state_n = ST_IDLE;
      count_n = load_val;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_stop) begin
            if (count != '0) state_n = ST_RUN;
            else begin
              state_n = ST_DONE;
              pulse_n = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (start_stop) state_n = ST_PAUSE;
          else if (tick && count != '0) begin
            count_n = count - 1'b1;
            if (count == WIDTH'(1)) begin
              state_n = ST_DONE;
              pulse_n = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_n = ST_RUN;
        end
        ST_DONE: begin
          count_n = '0;
          if (start_stop) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable synchronous down counter with run/pause control.
- Complements the existing synchronous up counter: counts from a loaded value down to zero, then stops and flags completion.
- Sits behind the board's debounce stage. `load` and `start_stop` arrive as clean single-cycle pulses in the `clk` domain.
- Drives the same 4-bit LED/7-seg display path as the up counter.

Parameters:
- WIDTH, 4, counter width in bits.
- DIV, 1000, clk cycles per count step (prescaler period); must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  one-cycle pulse: load `load_val` into the counter.
- load_val  input  WIDTH  value captured on `load`.
- start_stop  input  1  one-cycle pulse: start / pause / resume / acknowledge.
- count  output  WIDTH  current counter value.
- running  output  1  high while in RUN.
- done  output  1  level, high while in DONE.
- done_pulse  output  1  single-cycle pulse on the cycle DONE is entered.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, count=0, prescaler=DIV-1.
  - running=0, done=0, done_pulse=0.
  - Deassertion takes effect at the next clk edge. Reset asserted mid-RUN aborts immediately, with no done_pulse.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: load > start_stop > prescaler tick.
- load, any state:
  - count <= load_val; prescaler <= DIV-1; state <= IDLE; done <= 0.
  - A coincident start_stop is ignored.
  - load_val==0 still goes to IDLE.
- IDLE + start_stop:
  - count!=0 -> RUN.
  - count==0 -> DONE, with done_pulse=1 for one cycle.
- RUN:
  - Prescaler decrements every cycle.
  - When prescaler==0: it reloads DIV-1 and count decrements by 1.
  - A decrement taking count from 1 to 0 moves to DONE the same edge, so done=1 and done_pulse=1 appear the cycle count reads 0.
  - start_stop -> PAUSE; the prescaler tick in that cycle is suppressed.
- PAUSE:
  - count and prescaler frozen.
  - start_stop -> RUN, resuming from the held prescaler value, not reloaded.
- DONE:
  - count held at 0; prescaler idle at DIV-1.
  - start_stop -> IDLE, done <= 0.
- Arithmetic:
  - Count never wraps below 0.
  - Step latency from entering RUN is exactly DIV cycles per decrement: first decrement DIV cycles after the RUN-entry edge.
  - DIV==1 decrements every cycle in RUN.
- Outputs:
  - All outputs are registered. running and done are decoded from the state register.
  - done_pulse is never high for more than one cycle.

Decomposition:
- Shared package/header:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3.
  - Default DIV constant.
- Sub-module tick_divider, one natural split:
  - Inputs: clk, reset, en, clr.
  - Output: tick.
  - Parameter: DIV.
  - Down-counts DIV-1..0 while en; clr reloads to DIV-1.
  - Reusable by the debounced up counter.
- Top level holds the FSM and the count register.

Test Plan (bench uses DIV=4, WIDTH=4):
- Reset check: reset=0 mid-run with count=7 -> count=0, running=0, done=0 immediately, without waiting for a clk edge; after release, state is IDLE.
- Basic countdown: load 3, start_stop -> count 3,2,1,0 at 4, 8, 12 cycles after RUN entry; done_pulse high exactly at cycle 12; done stays 1; count stays 0 for 20 more cycles.
- Pause/resume: load 5, start, pause 2 cycles after the first decrement (count=4) -> count holds 4 for 10 cycles; resume -> next decrement 2 cycles after resume (prescaler retained).
- Load priority: in RUN at count=6, assert load (load_val=9) and start_stop in the same cycle -> count=9, state IDLE, running=0, no pause.
- Zero start: load 0 then start_stop -> done=1 with a one-cycle done_pulse next edge; a second start_stop -> IDLE, done=0, count=0.
- Max value and DIV=1 variant: load 15 with DIV=1, start -> count reaches 0 after exactly 15 cycles; no wrap to 15 afterwards.
